// File: rtl/melody_game_engine.sv
// melody_game_engine: plays a growing melody, then checks the player's key presses against it.
// Define GAME_LIVES_EN to limit misses to LIVES; otherwise misses are unlimited.
module melody_game_engine #(
    parameter int NOTE_W     = 3,
    parameter int MAX_NOTES  = 8,
    parameter int START_LEN  = 3,
    parameter int TICK_DIV   = 5000,
    parameter int TONE_TICKS = 2,
    parameter int GAP_TICKS  = 2,
    parameter int LIVES      = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 load_en,
    input  logic [MAX_NOTES*NOTE_W-1:0]          load_data,
    input  logic                                 start,
    input  logic                                 key_valid,
    input  logic [NOTE_W-1:0]                    key_code,
    output logic [NOTE_W-1:0]                    piezo_out,
    output logic [NOTE_W-1:0]                    led_out,
    output logic                                 playing,
    output logic                                 awaiting_key,
    output logic                                 miss,
    output logic                                 game_end,
    output logic [$clog2(MAX_NOTES+1)-1:0]       cur_len,
    output logic [(MAX_NOTES>1 ? $clog2(MAX_NOTES) : 1)-1:0] key_index,
    output logic [$clog2(LIVES+1)-1:0]           lives_left,
    output logic                                 game_lost
);
    localparam int LW   = $clog2(MAX_NOTES+1);
    localparam int IW   = MAX_NOTES > 1 ? $clog2(MAX_NOTES) : 1;
    localparam int VW   = $clog2(LIVES+1);
    localparam int TW   = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int PMAX = TONE_TICKS > GAP_TICKS ? TONE_TICKS : GAP_TICKS;
    localparam int PW   = $clog2(PMAX+1);

    typedef enum logic [2:0] {IDLE, PLAY_ON, PLAY_OFF, WAIT_KEY, ECHO, DONE} state_t;

    state_t                      state, state_n;
    logic [MAX_NOTES*NOTE_W-1:0] melody;
    logic                        loaded, match;
    logic [NOTE_W-1:0]           key_tone, note;
    logic [IW-1:0]               play_idx;
    logic [TW-1:0]               tcnt;
    logic [PW-1:0]               pcnt;
    logic tick, tone_done, gap_done, play_last, key_last, len_max, out_of_lives, ready;

    always_comb begin
        note      = melody[play_idx*NOTE_W +: NOTE_W];
        tick      = tcnt == TW'(TICK_DIV-1);
        tone_done = tick && pcnt == PW'(TONE_TICKS-1);
        gap_done  = tick && pcnt == PW'(GAP_TICKS-1);
        play_last = LW'(play_idx) == cur_len - 1'b1;
        key_last  = LW'(key_index) == cur_len - 1'b1;
        len_max   = cur_len == LW'(MAX_NOTES);
        ready     = state == IDLE || state == DONE;
        state_n   = state;
        case (state)
            IDLE:     if (start && loaded && !load_en) state_n = PLAY_ON;
            PLAY_ON:  if (tone_done) state_n = PLAY_OFF;
            PLAY_OFF: if (gap_done) state_n = play_last ? WAIT_KEY : PLAY_ON;
            WAIT_KEY: if (key_valid) state_n = ECHO;
            ECHO:     if (tone_done) state_n = !match ? (out_of_lives ? DONE : PLAY_ON) :
                                               !key_last ? WAIT_KEY : len_max ? DONE : PLAY_ON;
            DONE:     if (load_en) state_n = IDLE;
                      else if (start && loaded) state_n = PLAY_ON;
            default:  state_n = IDLE;
        endcase
    end

    assign piezo_out    = state == PLAY_ON ? note : state == ECHO ? key_tone : '0;
    assign led_out      = piezo_out;
    assign playing      = state == PLAY_ON || state == PLAY_OFF;
    assign awaiting_key = state == WAIT_KEY;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            melody    <= '0;
            loaded    <= 1'b0;
            match     <= 1'b0;
            key_tone  <= '0;
            play_idx  <= '0;
            key_index <= '0;
            cur_len   <= LW'(START_LEN);
            tcnt      <= '0;
            pcnt      <= '0;
            miss      <= 1'b0;
            game_end  <= 1'b0;
        end else begin
            state <= state_n;
            miss  <= 1'b0;
            // every phase starts from a cleared prescaler so its length is exact
            if (state_n != state) begin
                tcnt <= '0;
                pcnt <= '0;
            end else if (tick) begin
                tcnt <= '0;
                pcnt <= pcnt + 1'b1;
            end else tcnt <= tcnt + 1'b1;
            if (ready && load_en) begin
                melody   <= load_data;
                loaded   <= 1'b1;
                game_end <= 1'b0;
            end
            if (ready && state_n == PLAY_ON) begin
                cur_len   <= LW'(START_LEN);
                play_idx  <= '0;
                key_index <= '0;
                game_end  <= 1'b0;
            end
            if (state == PLAY_OFF && gap_done) begin
                if (play_last) key_index <= '0;
                else play_idx <= play_idx + 1'b1;
            end
            if (state == WAIT_KEY && key_valid) begin
                match    <= key_code == melody[key_index*NOTE_W +: NOTE_W];
                key_tone <= key_code;
            end
            if (state == ECHO && tone_done) begin
                play_idx <= '0;
                miss     <= !match;
                if (!match) key_index <= '0;
                else if (!key_last) key_index <= key_index + 1'b1;
                else if (!len_max) begin
                    cur_len   <= cur_len + 1'b1;
                    key_index <= '0;
                end
                if (state_n == DONE) game_end <= 1'b1;
            end
        end
    end

`ifdef GAME_LIVES_EN
    assign out_of_lives = lives_left == VW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            lives_left <= VW'(LIVES);
            game_lost  <= 1'b0;
        end else begin
            if (ready && load_en) game_lost <= 1'b0;
            if (ready && state_n == PLAY_ON) begin
                lives_left <= VW'(LIVES);
                game_lost  <= 1'b0;
            end
            if (state == ECHO && tone_done && !match) begin
                lives_left <= lives_left - 1'b1;
                if (out_of_lives) game_lost <= 1'b1;
            end
        end
    end
`else
    assign out_of_lives = 1'b0;
    assign lives_left   = '0;
    assign game_lost    = 1'b0;
`endif
endmodule

// File: tb/tb_melody_game_engine.sv
// tb_melody_game_engine: directed and randomized games checked against a rule-level game model.
module tb_melody_game_engine;
    localparam int NW = 4, MN = 8, SL = 3, TD = 4, TT = 2, GT = 2, LV = 2;
    localparam int PH = TD*TT, GPH = TD*GT;
`ifdef GAME_LIVES_EN
    localparam bit LIVES_EN = 1'b1;
`else
    localparam bit LIVES_EN = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b1, load_en = 1'b0, start = 1'b0, key_valid = 1'b0;
    logic [MN*NW-1:0] load_data = '0;
    logic [NW-1:0] key_code = '0;
    logic [NW-1:0] piezo_out, led_out;
    logic playing, awaiting_key, miss, game_end, game_lost;
    logic [3:0] cur_len;
    logic [2:0] key_index;
    logic [1:0] lives_left;

    melody_game_engine #(.NOTE_W(NW), .MAX_NOTES(MN), .START_LEN(SL), .TICK_DIV(TD),
                         .TONE_TICKS(TT), .GAP_TICKS(GT), .LIVES(LV)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_data(load_data), .start(start),
        .key_valid(key_valid), .key_code(key_code), .piezo_out(piezo_out), .led_out(led_out),
        .playing(playing), .awaiting_key(awaiting_key), .miss(miss), .game_end(game_end),
        .cur_len(cur_len), .key_index(key_index), .lives_left(lives_left), .game_lost(game_lost));

    always #5 clk = ~clk;

    int checks = 0, passed = 0, miss_cnt = 0;
    int mel[MN];
    int m_len, m_kidx, m_lives, m_miss = 0;
    bit m_end, m_lost, inj_next = 0;

    always @(posedge clk) begin
        #1;
        if (miss) miss_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic model_start();
        m_len = SL; m_kidx = 0; m_lives = LIVES_EN ? LV : 0; m_end = 0; m_lost = 0;
    endtask

    task automatic load_mel();
        for (int i = 0; i < MN; i++) load_data[i*NW +: NW] = mel[i][NW-1:0];
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // samples one phase of n cycles; optionally slips in a stray key press
    task automatic phase(input string tag, input int exp, input bit pl, input int n, input bit inj);
        int bad = 0;
        logic [NW-1:0] e;
        e = exp[NW-1:0];
        for (int c = 0; c < n; c++) begin
            if (piezo_out !== e || led_out !== e || playing !== pl || awaiting_key !== 1'b0) bad++;
            key_valid = inj && c == 3;
            key_code  = mel[0][NW-1:0];
            @(negedge clk);
        end
        key_valid = 1'b0;
        chk(tag, bad, 0);
    endtask

    task automatic play_round();
        bit inj = inj_next;
        inj_next = 0;
        for (int i = 0; i < m_len; i++) begin
            phase("tone", mel[i], 1'b1, PH, inj && i == 0);
            phase("gap", 0, 1'b1, GPH, 1'b0);
        end
        chk("round_await", awaiting_key, 1);
        chk("round_kidx", key_index, 0);
        chk("round_len", cur_len, m_len);
    endtask

    task automatic start_game();
        model_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        play_round();
    endtask

    task automatic press(input int k);
        bit replay = 0;
        key_code  = k[NW-1:0];
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        phase("echo", k, 1'b0, PH, 1'b0);
        if (k != mel[m_kidx]) begin
            m_miss++;
            m_kidx = 0;
            if (LIVES_EN && m_lives == 1) begin
                m_lives = 0; m_end = 1; m_lost = 1;
            end else begin
                if (LIVES_EN) m_lives--;
                replay = 1;
            end
        end else if (m_kidx < m_len-1) m_kidx++;
        else if (m_len < MN) begin
            m_len++; m_kidx = 0; replay = 1;
        end else m_end = 1;
        chk("miss_cnt", miss_cnt, m_miss);
        chk("cur_len", cur_len, m_len);
        chk("key_index", key_index, m_kidx);
        chk("game_end", game_end, m_end);
        chk("game_lost", game_lost, m_lost);
        chk("lives_left", lives_left, m_lives);
        chk("awaiting", awaiting_key, !m_end && !replay);
        chk("playing", playing, replay);
        if (replay) play_round();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_piezo"}, piezo_out, 0);
        chk({tag, "_led"}, led_out, 0);
        chk({tag, "_playing"}, playing, 0);
        chk({tag, "_await"}, awaiting_key, 0);
        chk({tag, "_miss"}, miss, 0);
        chk({tag, "_end"}, game_end, 0);
        chk({tag, "_lost"}, game_lost, 0);
        chk({tag, "_kidx"}, key_index, 0);
        chk({tag, "_len"}, cur_len, SL);
        chk({tag, "_lives"}, lives_left, LIVES_EN ? LV : 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < MN; i++) mel[i] = i + 1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("rst");

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_unloaded", playing, 0);
        load_en = 1'b1; start = 1'b1;
        for (int i = 0; i < MN; i++) load_data[i*NW +: NW] = mel[i][NW-1:0];
        @(negedge clk);
        load_en = 1'b0; start = 1'b0;
        chk("start_with_load", playing, 0);

        start_game();
        press(1);
        press(5);
        press(1);
        press(2);
        inj_next = 1;
        press(3);

        key_code = 4'd1; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_echo", piezo_out, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("midrst");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_after_rst", playing, 0);

        load_mel();
        start_game();
        while (!m_end) press(mel[m_kidx]);
        chk("win_piezo", piezo_out, 0);
        key_code = mel[0][NW-1:0]; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("done_end", game_end, 1);
        chk("done_piezo", piezo_out, 0);
        chk("done_await", awaiting_key, 0);
        chk("done_len", cur_len, MN);
        chk("done_miss", miss_cnt, m_miss);
        load_mel();
        chk("reload_end", game_end, 0);
        chk("reload_playing", playing, 0);

`ifdef GAME_LIVES_EN
        start_game();
        press(mel[0] + 1);
        press(mel[0] + 2);
        chk("lost_flag", game_lost, 1);
        repeat (4) @(negedge clk);
        chk("lost_idle", playing, 0);
        load_mel();
        chk("lost_cleared", game_lost, 0);
`endif

        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < MN; i++) mel[i] = $urandom_range(1, 15);
            load_mel();
            start_game();
            n = 0;
            while (!m_end && n < 400) begin
                press(($urandom_range(0, 7) == 0) ? (mel[m_kidx] ^ $urandom_range(1, 15)) : mel[m_kidx]);
                n++;
            end
            chk("rand_game_over", m_end && n < 400, 1);
            chk("rand_end", game_end, 1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
